// File: rtl/noc_rr_timeout_arbiter.sv
// noc_rr_timeout_arbiter
//   N-input output-port arbiter for the NoC router. It grants one requester at
//   a time with rotating round-robin priority. Each grant is bounded by a
//   per-input limit, loaded from the length field of that input's head flit.
//   A limit of 0 lets the owner hold the grant for as long as it requests.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous, active-high reset
//   req        per-channel level request
//   flit_id    per-channel flit type, channel i = [i*ID_W +: ID_W]
//   length     per-channel packet length, channel i = [i*LEN_W +: LEN_W]
//   grant      registered one-hot grant, all-zero when idle
//   grant_idx  index of the granted channel, 0 when idle
//   busy       high whenever any grant is active
//   timeout    1-cycle pulse after a grant was released by its limit
module noc_rr_timeout_arbiter #(
    parameter int unsigned       NUM_PORTS = 5,
    parameter int unsigned       LEN_W     = 12,
    parameter int unsigned       ID_W      = 3,
    parameter logic [ID_W-1:0]   HEAD_ID   = ID_W'(1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS*ID_W-1:0]     flit_id,
    input  logic [NUM_PORTS*LEN_W-1:0]    length,
    output logic [NUM_PORTS-1:0]          grant,
    output logic [$clog2(NUM_PORTS)-1:0]  grant_idx,
    output logic                          busy,
    output logic                          timeout
);

    localparam int unsigned IDX_W = $clog2(NUM_PORTS);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  rr_ptr;
    logic [LEN_W-1:0]  hold_cnt;
    logic [LEN_W-1:0]  limit_q [NUM_PORTS];

    logic [IDX_W-1:0]  next_p_c;
    logic [IDX_W-1:0]  start_c;
    logic [IDX_W-1:0]  pick_c;
    logic              found_c;
    logic [LEN_W-1:0]  cur_limit_c;
    logic              expire_c;
    logic              keep_c;

    // (base + off) mod NUM_PORTS, for off < NUM_PORTS
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                   input int unsigned     off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_PORTS) begin
            s = s - NUM_PORTS;
        end
        return IDX_W'(s);
    endfunction

    // Round-robin search: from rr_ptr when idle, from the owner's successor on release
    always_comb begin
        next_p_c = wrap_add(grant_idx, 1);
        start_c  = (state_q == S_GRANT) ? next_p_c : rr_ptr;
        found_c  = 1'b0;
        pick_c   = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (!found_c && req[wrap_add(start_c, k)]) begin
                found_c = 1'b1;
                pick_c  = wrap_add(start_c, k);
            end
        end
    end

    // Limit check for the current owner. A >= compare keeps the grant bounded
    // when a head flit shrinks the limit below the cycles already held.
    always_comb begin
        cur_limit_c = limit_q[grant_idx];
        expire_c    = (cur_limit_c != '0) && (hold_cnt >= (cur_limit_c - LEN_W'(1)));
        keep_c      = req[grant_idx] && !expire_c;
    end

    // Grant state machine, limit latches and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant     <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
            rr_ptr    <= '0;
            hold_cnt  <= '0;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                limit_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (flit_id[i*ID_W +: ID_W] == HEAD_ID) begin
                    limit_q[i] <= length[i*LEN_W +: LEN_W];
                end
            end

            timeout <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (found_c) begin
                        state_q   <= S_GRANT;
                        grant     <= NUM_PORTS'(1) << pick_c;
                        grant_idx <= pick_c;
                        busy      <= 1'b1;
                        hold_cnt  <= '0;
                    end
                end

                S_GRANT: begin
                    if (keep_c) begin
                        // saturate rather than wrap in unlimited mode
                        if (hold_cnt != '1) begin
                            hold_cnt <= hold_cnt + LEN_W'(1);
                        end
                    end else begin
                        // still requesting here means the limit forced the release
                        timeout  <= req[grant_idx];
                        rr_ptr   <= next_p_c;
                        hold_cnt <= '0;
                        if (found_c) begin
                            grant     <= NUM_PORTS'(1) << pick_c;
                            grant_idx <= pick_c;
                            busy      <= 1'b1;
                        end else begin
                            state_q   <= S_IDLE;
                            grant     <= '0;
                            grant_idx <= '0;
                            busy      <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_rr_timeout_arbiter.sv
// tb_noc_rr_timeout_arbiter
//   Directed scenarios plus randomized traffic for noc_rr_timeout_arbiter,
//   checked against a cycle-level behavioural model of the arbitration rules.
module tb_noc_rr_timeout_arbiter;

    localparam int N  = 5;
    localparam int LW = 12;
    localparam int IW = 3;
    localparam int XW = $clog2(N);
    localparam int OW = N + XW + 2;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*IW-1:0]  flit_id;
    logic [N*LW-1:0]  length;
    logic [N-1:0]     grant;
    logic [XW-1:0]    grant_idx;
    logic             busy;
    logic             timeout;

    int checks   = 0;
    int failures = 0;

    // behavioural model: owner (-1 = idle), cycles held, rotation pointer, limits
    int m_owner;
    int m_hold;
    int m_rr;
    int m_lim [N];
    bit m_tmo;

    noc_rr_timeout_arbiter #(
        .NUM_PORTS (N),
        .LEN_W     (LW),
        .ID_W      (IW),
        .HEAD_ID   (3'b001)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .flit_id   (flit_id),
        .length    (length),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rr_search(input int start);
        int found;
        found = -1;
        for (int k = 0; k < N; k++) begin
            if (found < 0 && req[(start + k) % N]) found = (start + k) % N;
        end
        return found;
    endfunction

    function automatic logic [OW-1:0] model_outs();
        logic [N-1:0]  g;
        logic [XW-1:0] x;
        g = '0;
        x = '0;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            x = XW'(m_owner);
        end
        return {g, x, (m_owner >= 0), m_tmo};
    endfunction

    // advance the model by one clock using the inputs currently applied
    task automatic model_step();
        int lim;
        bit expired;
        if (rst) begin
            m_owner = -1;
            m_hold  = 0;
            m_rr    = 0;
            m_tmo   = 1'b0;
            for (int i = 0; i < N; i++) m_lim[i] = 0;
        end else begin
            m_tmo = 1'b0;
            if (m_owner < 0) begin
                m_owner = rr_search(m_rr);
                m_hold  = 0;
            end else begin
                lim     = m_lim[m_owner];
                expired = (lim != 0) && (m_hold >= lim - 1);
                if (req[m_owner] && !expired) begin
                    if (m_hold < (1 << LW) - 1) m_hold++;
                end else begin
                    m_tmo   = req[m_owner];
                    m_rr    = (m_owner + 1) % N;
                    m_owner = rr_search(m_rr);
                    m_hold  = 0;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (flit_id[i*IW +: IW] == 3'b001) m_lim[i] = int'(length[i*LW +: LW]);
            end
        end
    endtask

    task automatic set_head(input int port, input int len);
        flit_id[port*IW +: IW] = 3'b001;
        length[port*LW +: LW]  = LW'(len);
    endtask

    // one clock: model follows the applied inputs, outputs sampled 1ns after the edge
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        flit_id = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 5'b10110;
        tick();
        checks++;
        if ({grant, grant_idx, busy, timeout} !== OW'(0)) begin
            failures++;
            $display("FAIL reset_state got=%b want=%b", {grant, grant_idx, busy, timeout}, OW'(0));
        end
        rst = 1'b0;
        req = '0;
    endtask

    task automatic test_hold_unlimited();
        do_reset();
        req = 5'b00100;
        tick();
        checks++;
        if (grant !== 5'b00100) begin
            failures++;
            $display("FAIL unlimited_first_grant got=%b want=%b", grant, 5'b00100);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if ({grant, grant_idx, busy, timeout} !== model_outs() || grant !== 5'b00100 || timeout !== 1'b0) begin
                failures++;
                $display("FAIL unlimited_hold c=%0d got=%b want=%b", c, {grant, grant_idx, busy, timeout}, model_outs());
            end
        end
    endtask

    task automatic test_rotation();
        int want_idx;
        bit want_tmo;
        do_reset();
        for (int i = 0; i < N; i++) set_head(i, 3);
        tick();
        req = 5'b11111;
        for (int c = 0; c < 16; c++) begin
            tick();
            want_idx = (c / 3) % N;
            want_tmo = (c % 3 == 0) && (c > 0);
            checks++;
            if (grant_idx !== XW'(want_idx) || grant !== N'(1 << want_idx) || timeout !== want_tmo || busy !== 1'b1) begin
                failures++;
                $display("FAIL rotation c=%0d got idx=%0d tmo=%b busy=%b want idx=%0d tmo=%b", c, grant_idx, timeout, busy, want_idx, want_tmo);
            end
            checks++;
            if ({grant, grant_idx, busy, timeout} !== model_outs()) begin
                failures++;
                $display("FAIL rotation_model c=%0d got=%b want=%b", c, {grant, grant_idx, busy, timeout}, model_outs());
            end
        end
    endtask

    task automatic test_timeout_regrant();
        bit want_tmo;
        do_reset();
        set_head(1, 4);
        req = 5'b00010;
        for (int c = 0; c < 12; c++) begin
            tick();
            want_tmo = (c % 4 == 0) && (c > 0);
            checks++;
            if (grant !== 5'b00010 || timeout !== want_tmo) begin
                failures++;
                $display("FAIL timeout_regrant c=%0d got grant=%b tmo=%b want grant=%b tmo=%b", c, grant, timeout, 5'b00010, want_tmo);
            end
        end
    endtask

    task automatic test_drop();
        do_reset();
        req = 5'b00100;
        repeat (3) tick();
        req = 5'b10101;
        repeat (2) tick();
        checks++;
        if (grant !== 5'b00100) begin
            failures++;
            $display("FAIL drop_pre_hold got=%b want=%b", grant, 5'b00100);
        end
        req = 5'b10001;
        tick();
        checks++;
        if (grant !== 5'b10000 || grant_idx !== XW'(4) || timeout !== 1'b0) begin
            failures++;
            $display("FAIL drop_next_owner got grant=%b idx=%0d tmo=%b want grant=10000 idx=4 tmo=0", grant, grant_idx, timeout);
        end
        // rotation now starts at 0 after port 4 drops
        req = 5'b00011;
        tick();
        checks++;
        if ({grant, grant_idx, busy, timeout} !== model_outs() || grant !== 5'b00001) begin
            failures++;
            $display("FAIL drop_wrap got=%b want=%b", {grant, grant_idx, busy, timeout}, model_outs());
        end
    endtask

    task automatic test_head_shrink();
        do_reset();
        set_head(3, 10);
        req = 5'b01000;
        repeat (6) tick();
        set_head(3, 2);
        tick();
        checks++;
        if (grant !== 5'b01000 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL shrink_still_held got grant=%b tmo=%b want grant=01000 tmo=0", grant, timeout);
        end
        tick();
        checks++;
        if (grant !== 5'b01000 || timeout !== 1'b1) begin
            failures++;
            $display("FAIL shrink_release got grant=%b tmo=%b want grant=01000 tmo=1", grant, timeout);
        end
        tick();
        checks++;
        if ({grant, grant_idx, busy, timeout} !== model_outs() || timeout !== 1'b0) begin
            failures++;
            $display("FAIL shrink_after got=%b want=%b", {grant, grant_idx, busy, timeout}, model_outs());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 5'b01000;
        repeat (8) tick();
        checks++;
        if (grant !== 5'b01000) begin
            failures++;
            $display("FAIL midreset_setup got=%b want=%b", grant, 5'b01000);
        end
        rst = 1'b1;
        req = 5'b01010;
        tick();
        checks++;
        if ({grant, grant_idx, busy, timeout} !== OW'(0)) begin
            failures++;
            $display("FAIL midreset_clear got=%b want=%b", {grant, grant_idx, busy, timeout}, OW'(0));
        end
        rst = 1'b0;
        tick();
        checks++;
        if (grant !== 5'b00010 || grant_idx !== XW'(1)) begin
            failures++;
            $display("FAIL midreset_first got grant=%b idx=%0d want grant=00010 idx=1", grant, grant_idx);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) set_head(i, $urandom_range(0, 6));
            end
            rst = ($urandom_range(0, 149) == 0);
            tick();
            checks++;
            if ({grant, grant_idx, busy, timeout} !== model_outs() || !$onehot0(grant)) begin
                failures++;
                $display("FAIL random c=%0d got=%b want=%b", c, {grant, grant_idx, busy, timeout}, model_outs());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        req     = '0;
        flit_id = '0;
        length  = '0;
        m_owner = -1;
        m_hold  = 0;
        m_rr    = 0;
        m_tmo   = 1'b0;
        for (int i = 0; i < N; i++) m_lim[i] = 0;

        test_reset();
        test_hold_unlimited();
        test_rotation();
        test_timeout_regrant();
        test_drop();
        test_head_shrink();
        test_reset_mid();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
